// File: rtl/carry_skip_seq_adder_if.sv
// carry_skip_seq_adder_if: operand/result valid-ready bundle; CSB_SEQ_OVERFLOW_EN adds an overflow flag.
interface carry_skip_seq_adder_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CSB_SEQ_OVERFLOW_EN
    logic             overflow;
    modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout, overflow);
    modport slave  (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout, overflow);
`else
    modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout);
    modport slave  (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/carry_skip_seq_adder.sv
// carry_skip_seq_adder: multi-cycle adder reusing one carry_skip_block per slice, LSB first.
// Define CSB_SEQ_OVERFLOW_EN to add a registered signed-overflow flag.
module carry_skip_block #(parameter int W = 4) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         block_carry_out
);
    logic [W-1:0] p;
    logic [W:0]   c;
    always_comb begin
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++)
            c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
    end
    assign sum             = p ^ c[W-1:0];
    assign cout            = c[W];
    // All bits propagating lets the incoming carry bypass the ripple chain
    assign block_carry_out = (&p) ? cin : c[W];
endmodule

module carry_skip_seq_adder #(
    parameter int WIDTH       = 16,
    parameter int BLOCK_WIDTH = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    carry_skip_seq_adder_if.slave bus
);
    localparam int NBLK = WIDTH / BLOCK_WIDTH;
    localparam int IW   = NBLK > 1 ? $clog2(NBLK) : 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

    if (WIDTH % BLOCK_WIDTH != 0 || WIDTH <= 0) begin : g_bad_width
        $error("carry_skip_seq_adder: WIDTH must be a positive multiple of BLOCK_WIDTH");
    end

    logic [1:0]             state;
    logic [WIDTH-1:0]       a_reg, b_reg, sum_reg;
    logic                   carry_reg, cout_reg;
    logic [IW-1:0]          idx;
    logic [BLOCK_WIDTH-1:0] a_sl, b_sl, blk_sum;
    logic                   blk_carry, unused_ripple_cout, last;

    assign a_sl = a_reg[idx*BLOCK_WIDTH +: BLOCK_WIDTH];
    assign b_sl = b_reg[idx*BLOCK_WIDTH +: BLOCK_WIDTH];
    assign last = idx == IW'(NBLK-1);

    carry_skip_block #(.W(BLOCK_WIDTH)) u_blk (
        .a(a_sl),
        .b(b_sl),
        .cin(carry_reg),
        .sum(blk_sum),
        .cout(unused_ripple_cout),
        .block_carry_out(blk_carry)
    );

`ifdef CSB_SEQ_OVERFLOW_EN
    logic ovf_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_reg <= 1'b0;
        else if (state == RUN && last)
            ovf_reg <= (a_reg[WIDTH-1] ~^ b_reg[WIDTH-1]) & (blk_sum[BLOCK_WIDTH-1] ^ a_reg[WIDTH-1]);
    end
    assign bus.overflow = ovf_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_reg     <= bus.a;
                    b_reg     <= bus.b;
                    carry_reg <= bus.cin;
                    idx       <= '0;
                    sum_reg   <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    sum_reg[idx*BLOCK_WIDTH +: BLOCK_WIDTH] <= blk_sum;
                    carry_reg <= blk_carry;
                    if (last) begin
                        cout_reg <= blk_carry;
                        state    <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
endmodule

// File: tb/tb_carry_skip_seq_adder.sv
// tb_carry_skip_seq_adder: scoreboard bench for the 16-bit, 4-bit-slice sequential adder.
module tb_carry_skip_seq_adder;
    localparam int NBLK = 4;
    typedef struct packed { logic [15:0] s; logic c; logic o; } exp_t;

    logic clk, rst_n;
    exp_t q[$];
    exp_t last_e;
    int   tests = 0, fails = 0;
    int   n;

    carry_skip_seq_adder_if #(.WIDTH(16)) bus ();
    carry_skip_seq_adder #(.WIDTH(16), .BLOCK_WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] r;
        exp_t e;
        int k = 0;
        while (!bus.in_ready && k < 50) begin tick(); k++; end
        if (k >= 50) chk("in_ready_timeout", 0, 1);
        bus.a = a; bus.b = b; bus.cin = c; bus.in_valid = 1;
        r = 17'(a) + 17'(b) + 17'(c);
        e.s = r[15:0];
        e.c = r[16];
        e.o = (a[15] == b[15]) && (r[15] != a[15]);
        q.push_back(e);
        tick();
        chk("accepted_in_ready", bus.in_ready, 0);
        bus.in_valid = 0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 50) begin tick(); cyc++; end
        if (cyc >= 50) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic check_result();
        if (q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            last_e = q.pop_front();
            chk("sum", bus.sum, last_e.s);
            chk("cout", bus.cout, last_e.c);
`ifdef CSB_SEQ_OVERFLOW_EN
            chk("overflow", bus.overflow, last_e.o);
`endif
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        chk("out_valid_after_hs", bus.out_valid, 0);
        chk("in_ready_after_hs", bus.in_ready, 1);
    endtask

    task automatic op(input logic [15:0] a, input logic [15:0] b, input logic c, input int hold);
        int cyc;
        send(a, b, c);
        wait_out(cyc);
        chk("latency", cyc, NBLK);
        check_result();
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_sum", bus.sum, last_e.s);
            chk("hold_cout", bus.cout, last_e.c);
        end
        handshake();
    endtask

    initial begin
        rst_n = 0;
        bus.in_valid = 0; bus.a = '0; bus.b = '0; bus.cin = 0; bus.out_ready = 0;
        tick();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        rst_n = 1;
        tick();
        op(16'hFFFF, 16'h0001, 0, 0);
        op(16'h1234, 16'h4321, 1, 0);
        op(16'h8000, 16'h8000, 0, 0);
        op(16'hABCD, 16'h1357, 1, 6);
        // Operands churn while RUN; only the latched pair may count
        send(16'h00FF, 16'h0F01, 0);
        bus.in_valid = 1;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            chk("run_in_ready", bus.in_ready, 0);
            bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
            tick();
            n++;
        end
        chk("t4_latency", n, NBLK);
        check_result();
        bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 0; bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        chk("t4_idle_ready", bus.in_ready, 1);
        chk("t4_idle_valid", bus.out_valid, 0);
        send(16'h1111, 16'h2222, 0);
        wait_out(n);
        chk("t4b_latency", n, NBLK);
        check_result();
        handshake();
        send(16'h5555, 16'h1111, 0);
        tick();
        tick();
        rst_n = 0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_sum", bus.sum, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        void'(q.pop_back());
        tick();
        rst_n = 1;
        tick();
        op(16'h0001, 16'h0001, 1, 0);
        op(16'h7FFF, 16'h0001, 0, 0);
        op(16'hFFFF, 16'h0001, 0, 0);
        op(16'h8000, 16'hFFFF, 0, 1);
        for (int i = 0; i < 6; i++)
            op(16'($urandom), 16'($urandom), 1'($urandom), i % 3);
        chk("sb_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/carry_skip_seq_adder.md
Name: carry_skip_seq_adder

Overview:
- Multi-cycle WIDTH-bit adder that drives one shared carry_skip_block instance (BLOCK_WIDTH wide) with one operand slice per cycle, LSB slice first.
- Registers each slice's sum, and feeds that slice's block_carry_out back as the next slice's cin.
- It is the sequencing stage directly upstream of carry_skip_block: it feeds the block and consumes its outputs.
- Area-reduced alternative to a full-width carry-skip adder, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 16, total operand width; must be a positive multiple of BLOCK_WIDTH.
BLOCK_WIDTH, 4, width of the internal carry_skip_block instance.
NBLK, WIDTH/BLOCK_WIDTH (derived localparam), number of slices, i.e. RUN cycles per operation.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry in.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  registered sum.
cout  output  1  registered carry out of the MSB slice.

Interface decided: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; in_ready=1, out_valid=0, sum=0, cout=0.
  - Internal a/b registers, carry register and slice index all go to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a rising edge: latch a, b into operand registers; carry_reg<=cin; idx<=0; clear sum; go to RUN.
- RUN:
  - in_ready=0; the in_valid/a/b/cin inputs are ignored.
  - Each cycle the block is driven with slice idx of the latched a and b plus carry_reg.
  - On the edge: sum[idx*BLOCK_WIDTH +: BLOCK_WIDTH] <= block sum; carry_reg <= block_carry_out; idx <= idx+1.
  - On the edge where idx==NBLK-1: cout <= block_carry_out; go to DONE.
- DONE:
  - out_valid=1; sum and cout are held stable while out_ready=0.
  - On out_valid&&out_ready: go to IDLE; out_valid falls and in_ready rises the next cycle.
  - No input is accepted in the same cycle as the output handshake.
- Latency and throughput:
  - Accept edge T gives out_valid high after edge T+NBLK, i.e. NBLK cycles.
  - Minimum initiation interval is NBLK+2 cycles.
- Arithmetic:
  - {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned, no saturation.
  - The block's cout output (its internal ripple carry) is unused; block_carry_out alone chains the slices.
- Boundary conditions:
  - NBLK=1: RUN lasts exactly one cycle.
  - idx wraps only by a state change, never past NBLK-1.
  - Reset asserted mid-RUN or mid-DONE aborts the operation: the result is discarded and out_valid goes to 0 immediately (asynchronously).
  - in_valid held high through RUN/DONE is not consumed; it is accepted on the first IDLE cycle.
- Parameter check: WIDTH%BLOCK_WIDTH!=0 triggers a $error at elaboration.

Optional Feature:
- Macro: CSB_SEQ_OVERFLOW_EN.
- When defined:
  - Adds output port overflow (1 bit), reset 0, registered alongside cout at the final RUN edge.
  - overflow = two's-complement signed overflow = a[MSB] ~^ b[MSB] AND (sum[MSB] ^ a[MSB]), evaluated on the latched operands.
  - overflow is valid and held under the same out_valid rules as sum.
- When undefined: no overflow port and no overflow logic; behaviour otherwise identical.

Test Plan (WIDTH=16, BLOCK_WIDTH=4):
1. a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> out_valid rises exactly 4 cycles after accept; sum=0x0000, cout=1; in_ready returns to 1 one cycle after the output handshake.
2. a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; a second op a=0x8000, b=0x8000, cin=0 sent back-to-back -> sum=0x0000, cout=1.
3. Back-pressure: out_ready=0 for 6 cycles after out_valid -> sum/cout stable, in_ready=0 throughout; raise out_ready -> one handshake only, out_valid=0 next cycle.
4. Change a/b/cin to random values every cycle during RUN with in_valid=1 -> result equals the latched operands (0x00FF+0x0F01, cin=0 -> sum=0x1000, cout=0); the new op is accepted only after returning to IDLE.
5. Assert rst_n low after 2 RUN cycles -> out_valid=0, sum=0, in_ready=1 immediately; after release, a=0x0001, b=0x0001, cin=1 -> sum=0x0003, cout=0.
6. With CSB_SEQ_OVERFLOW_EN: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, overflow=1; a=0xFFFF, b=0x0001 -> overflow=0, cout=1.
